// File: rtl/phy_rx_serial_to_parallel.sv
// phy_rx_serial_to_parallel: PCIe lane RX deserializer, COM (K28.5) byte alignment and lock
//   clk_32f   in  bit-rate clock, rising edge
//   reset     in  asynchronous active-low reset
//   data_in   in  serial bit, MSB of each byte first
//   data_out  out last completed byte while locked (registered)
//   byte_strb out one-cycle pulse when data_out updates
//   valid_out out strobed byte is data (not COM_BYTE)
//   active    out lane aligned and locked
//   Optional macro PHY_RX_REALIGN_EN: a misaligned COM while locked drops lock and realigns.
module phy_rx_serial_to_parallel #(
  parameter logic [7:0] COM_BYTE       = 8'hBC,
  parameter int         COM_LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       byte_strb,
  output logic       valid_out,
  output logic       active
);
  localparam int BW = $clog2(COM_LOCK_COUNT + 1);
  localparam logic [BW-1:0] LOCK_MAX = BW'(COM_LOCK_COUNT);
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
  state_t        state;
  logic [6:0]    sr;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] bc_cnt;
  logic [7:0]    nxt;
  logic          is_com;
  logic          boundary;
  // only the 7 most recent bits are kept; the incoming bit completes the window
  assign nxt      = {sr, data_in};
  assign is_com   = nxt == COM_BYTE;
  assign boundary = bit_cnt == 3'd7;
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      data_out  <= 8'h00;
      byte_strb <= 1'b0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr        <= nxt[6:0];
      byte_strb <= 1'b0;
      valid_out <= 1'b0;
      case (state)
        SEARCH: if (is_com) begin
          bit_cnt <= '0;
          bc_cnt  <= BW'(1);
          state   <= COM_LOCK_COUNT == 1 ? LOCKED : ALIGN;
          active  <= COM_LOCK_COUNT == 1;
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (!is_com) begin
              bc_cnt <= '0;
              state  <= SEARCH;
            end else if (bc_cnt >= LOCK_MAX - 1'b1) begin
              bc_cnt <= LOCK_MAX;
              state  <= LOCKED;
              active <= 1'b1;
            end else
              bc_cnt <= bc_cnt + 1'b1;
          end
        end
        LOCKED: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            data_out  <= nxt;
            byte_strb <= 1'b1;
            valid_out <= !is_com;
          end
`ifdef PHY_RX_REALIGN_EN
          // a COM off the established phase restarts alignment at its own phase
          else if (is_com) begin
            active  <= 1'b0;
            bit_cnt <= '0;
            bc_cnt  <= BW'(1);
            state   <= ALIGN;
          end
`endif
        end
        default: state <= SEARCH;
      endcase
    end
  end
endmodule

// File: tb/tb_phy_rx_serial_to_parallel.sv
// tb_phy_rx_serial_to_parallel: directed table and sequence checks for the RX deserializer
module tb_phy_rx_serial_to_parallel;
  logic       clk_32f = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       byte_strb;
  logic       valid_out;
  logic       active;
  int         checks = 0;
  int         errors = 0;
  typedef struct {
    logic [7:0] b;
    logic       r;
    logic       a;
    logic       s;
    logic       v;
    logic [7:0] d;
  } vec_t;
  vec_t tbl[17];
  phy_rx_serial_to_parallel dut (
    .clk_32f(clk_32f),
    .reset(reset),
    .data_in(data_in),
    .data_out(data_out),
    .byte_strb(byte_strb),
    .valid_out(valid_out),
    .active(active)
  );
  always #5 clk_32f = ~clk_32f;
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  task automatic chk_all(input string n, input logic a, input logic s, input logic v, input logic [7:0] d);
    chk({n, " active"}, {7'd0, active}, {7'd0, a});
    chk({n, " byte_strb"}, {7'd0, byte_strb}, {7'd0, s});
    chk({n, " valid_out"}, {7'd0, valid_out}, {7'd0, v});
    chk({n, " data_out"}, data_out, d);
  endtask
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask
  task automatic send_byte(input string n, input logic [7:0] b, input logic a, input logic s,
                           input logic v, input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i != 0) chk({n, " midbyte strb"}, {7'd0, byte_strb}, 8'd0);
    end
    chk_all(n, a, s, v, d);
  endtask
  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask
  initial begin
    tbl[0]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{8'hBC, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{8'hAB, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAB};
    tbl[5]  = '{8'hFD, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFD};
    tbl[6]  = '{8'h34, 1'b0, 1'b1, 1'b1, 1'b1, 8'h34};
    tbl[7]  = '{8'hBC, 1'b0, 1'b1, 1'b1, 1'b0, 8'hBC};
    tbl[8]  = '{8'h56, 1'b0, 1'b1, 1'b1, 1'b1, 8'h56};
    tbl[9]  = '{8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[14] = '{8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[15] = '{8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[16] = '{8'hBC, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    // held in reset while the line toggles
    for (int i = 0; i < 100; i++) begin
      send_bit(i[0]);
      if (i % 25 == 24) chk_all("in reset", 1'b0, 1'b0, 1'b0, 8'h00);
    end
    reset = 1'b1;
    send_byte("post reset idle", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 17; k++) begin
      if (tbl[k].r) pulse_reset();
      send_byte($sformatf("vec%0d", k), tbl[k].b, tbl[k].a, tbl[k].s, tbl[k].v, tbl[k].d);
    end
    // junk prefix shifts the byte phase by 3 bits
    pulse_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 0; k < 4; k++) send_byte("shifted com", 8'hBC, k == 3, 1'b0, 1'b0, 8'h00);
    send_byte("shifted data", 8'h9A, 1'b1, 1'b1, 1'b1, 8'h9A);
    // asynchronous reset in the middle of a byte
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b0;
    #1;
    chk_all("async reset", 1'b0, 1'b0, 1'b0, 8'h00);
    send_bit(1'b1);
    chk_all("reset held", 1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) send_byte("relock com", 8'hBC, k == 3, 1'b0, 1'b0, 8'h00);
    send_byte("relock data", 8'h55, 1'b1, 1'b1, 1'b1, 8'h55);
    // COM arriving 3 bits off the locked phase; a lock boundary falls inside it
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    for (int i = 7; i >= 3; i--) send_bit(1'b1 & (8'hBC >> i));
    chk_all("boundary in com", 1'b1, 1'b1, 1'b1, 8'h17);
    for (int i = 2; i >= 0; i--) send_bit(1'b1 & (8'hBC >> i));
`ifdef PHY_RX_REALIGN_EN
    chk_all("misaligned com", 1'b0, 1'b0, 1'b0, 8'h17);
    for (int k = 0; k < 3; k++) send_byte("realign com", 8'hBC, k == 2, 1'b0, 1'b0, 8'h17);
    send_byte("realign data", 8'h77, 1'b1, 1'b1, 1'b1, 8'h77);
`else
    chk_all("misaligned com", 1'b1, 1'b0, 1'b0, 8'h17);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    chk_all("phase kept", 1'b1, 1'b1, 1'b1, 8'h80);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
